// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 UART receiver with bit-centre sampling and valid/ready byte output
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, asserted high
//   rxd        serial input, idle high, LSB first, asynchronous to clk
//   rx_data    received byte, stable while rx_valid is high and rx_ready is low
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accepts the byte when rx_valid && rx_ready at a rising edge
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a completed byte is dropped because the output is occupied
//   busy       high whenever the receiver is not idle

module uart_rx_frame #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BIT_PERIOD  = CLK_FREQ / BAUD_RATE,
    parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(BIT_PERIOD);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic [1:0]       sync;
    logic             rxd_s;
    logic             deliver;
    logic             stop_bad;

    // Two-flop synchronizer; resets to the idle-high line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxd_s = sync[1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rxd_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                        bit_next   = '0;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next            = '0;
                    shreg_next[bit_idx] = rxd_s;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new frame may start.
                cnt_next = '0;
                if (rxd_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output port: a new byte may replace the held one only if the held one
    // is being accepted in the same cycle; otherwise the new byte is dropped.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed scoreboard bench for uart_rx_frame

module tb_uart_rx_frame;

    localparam int BP      = 434;
    localparam int LATENCY = 4126;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         n_acc;
    int         n_ferr;
    int         n_ovr;
    int         last_rise_cyc;
    logic       prev_valid;
    logic [7:0] exp_q[$];

    uart_rx_frame dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (rx_valid && !prev_valid) last_rise_cyc = cyc;
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (rx_valid && rx_ready) begin
                n_acc++;
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_byte observed=%0h expected=none", rx_data);
                end
                if (exp_q.size() != 0) chk("sb_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Called #1 after a rising edge; each line level lasts bp rising edges.
    task automatic send_byte(input logic [7:0] b, input int bp, input logic stop);
        rxd = 1'b0;
        repeat (bp) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bp) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (bp) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] nominal [5];
        int         c0;
        int         acc0;
        int         ferr0;
        int         ovr0;
        nominal = '{8'hA5, 8'h3C, 8'h7F, 8'h00, 8'hFF};
        n_checks = 0; n_fail = 0; cyc = 0;
        n_acc = 0; n_ferr = 0; n_ovr = 0; last_rise_cyc = 0; prev_valid = 1'b0;
        rst_n = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
        idle(3);
        chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
        chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
        chk("reset_overrun", {31'h0, overrun}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b0;
        idle(5);

        // Nominal frames, back to back.
        acc0 = n_acc;
        for (int k = 0; k < 5; k++) begin
            c0 = cyc;
            exp_q.push_back(nominal[k]);
            send_byte(nominal[k], BP, 1'b1);
            n_checks++;
            assert ((last_rise_cyc - c0 >= LATENCY - 1) && (last_rise_cyc - c0 <= LATENCY + 1)) else begin
                n_fail++;
                $error("FAIL latency observed=%0d expected=%0d", last_rise_cyc - c0, LATENCY);
            end
        end
        idle(10);
        chk("nominal_count", n_acc - acc0, 5);
        chk("nominal_ferr", n_ferr, 0);
        chk("nominal_ovr", n_ovr, 0);

        // Glitch: 100 low cycles then high.
        acc0 = n_acc;
        rxd = 1'b0;
        idle(20);
        chk("glitch_busy_high", {31'h0, busy}, 32'h1);
        idle(80);
        rxd = 1'b1;
        idle(300);
        chk("glitch_busy_low", {31'h0, busy}, 32'h0);
        chk("glitch_no_valid", n_acc - acc0, 0);
        chk("glitch_no_ferr", n_ferr, 0);

        // Framing error with the line held low afterwards.
        acc0 = n_acc;
        send_byte(8'h55, BP, 1'b0);
        rxd = 1'b0;
        idle(2000);
        chk("ferr_pulse", n_ferr, 1);
        chk("ferr_no_valid", n_acc - acc0, 0);
        chk("ferr_break_busy", {31'h0, busy}, 32'h1);
        rxd = 1'b1;
        idle(10);
        chk("ferr_break_exit", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BP, 1'b1);
        idle(10);
        chk("ferr_recover", n_acc - acc0, 1);

        // Overrun under backpressure.
        rx_ready = 1'b0;
        ovr0 = n_ovr;
        exp_q.push_back(8'h7F);
        send_byte(8'h7F, BP, 1'b1);
        send_byte(8'h00, BP, 1'b1);
        idle(10);
        chk("ovr_data_held", {24'h0, rx_data}, 32'h7F);
        chk("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
        chk("ovr_pulse", n_ovr - ovr0, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(1);
        chk("ovr_valid_drop", {31'h0, rx_valid}, 32'h0);

        // Ready asserted exactly on the second byte's delivery cycle.
        ovr0 = n_ovr;
        exp_q.push_back(8'h7F);
        send_byte(8'h7F, BP, 1'b1);
        exp_q.push_back(8'h00);
        fork
            send_byte(8'h00, BP, 1'b1);
            begin
                repeat (LATENCY - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(10);
        chk("same_cycle_data", {24'h0, rx_data}, 32'h00);
        chk("same_cycle_valid", {31'h0, rx_valid}, 32'h1);
        chk("same_cycle_no_ovr", n_ovr - ovr0, 0);
        rx_ready = 1'b1;
        idle(2);

        // Reset during data bit 4, held until the line is idle again.
        acc0 = n_acc;
        fork
            send_byte(8'hA5, BP, 1'b1);
            begin
                repeat (5 * BP + 200) @(posedge clk);
                #1 rst_n = 1'b1;
                idle(3);
                chk("midrst_busy", {31'h0, busy}, 32'h0);
                chk("midrst_valid", {31'h0, rx_valid}, 32'h0);
            end
        join
        idle(5);
        chk("midrst_data", {24'h0, rx_data}, 32'h0);
        chk("midrst_ferr", {31'h0, frame_err}, 32'h0);
        chk("midrst_ovr", {31'h0, overrun}, 32'h0);
        rst_n = 1'b0;
        idle(20);
        chk("midrst_no_byte", n_acc - acc0, 0);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, BP, 1'b1);
        idle(10);
        chk("midrst_recover", n_acc - acc0, 1);

        // Baud skew.
        acc0 = n_acc;
        ferr0 = n_ferr;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 425, 1'b1);
        idle(50);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 443, 1'b1);
        idle(50);
        chk("skew_count", n_acc - acc0, 2);
        chk("skew_no_ferr", n_ferr - ferr0, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receiver for 8N1 framing. Samples the serial `rxd` line at bit centres using a clock-cycle bit timer, then presents each received byte on a valid/ready output port. It also flags glitched start bits, framing errors and overruns. It sits between the board `rxd` pin and the receive FIFO, and is the receiving end of the same serial link that the transmit path and the byte-level UART benches drive.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `BIT_PERIOD`, CLK_FREQ/BAUD_RATE (434): clock cycles per bit, integer division.
- `HALF_PERIOD`, BIT_PERIOD/2 (217): cycles from start edge to start-bit centre.
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-high.
- `rxd`, in, 1: serial input, idle high, LSB first, asynchronous to `clk`.
- `rx_data`, out, 8: received byte; valid while `rx_valid`=1.
- `rx_valid`, out, 1: byte available; held until accepted.
- `rx_ready`, in, 1: consumer accepts the byte when `rx_valid && rx_ready` at a rising edge.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped because the output is still occupied.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- Input conditioning: 2-FF synchronizer; `rxd_s` lags `rxd` by 2 cycles. The synchronizer flops reset to 1.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. State is IDLE and counters are 0.
- Reset mid-frame aborts the frame immediately; no partial byte is ever presented.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxd_s`=0, go to START and clear the cycle counter.
  - START: when the counter reaches HALF_PERIOD-1, sample `rxd_s`.
    - If 1 (glitch), return to IDLE with no flags.
    - If 0, go to DATA and clear the counter and the bit index.
  - DATA: when the counter reaches BIT_PERIOD-1, shift `rxd_s` into the shift register at position bit index (LSB first) and clear the counter.
    - After bit index 7, go to STOP.
  - STOP: when the counter reaches BIT_PERIOD-1, sample `rxd_s`.
    - If 1, deliver the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Counter width: clog2(BIT_PERIOD) bits. The counter never wraps inside a bit.
- Delivery, on the stop-sample cycle:
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1: load `rx_data` and set `rx_valid`=1.
  - If `rx_valid`=1 with `rx_ready`=0: keep the old `rx_data`, keep `rx_valid`=1 and pulse `overrun`.
- Handshake:
  - `rx_valid` clears the cycle after `rx_valid && rx_ready`, unless a new byte is delivered in that same cycle; then it stays 1 with the new data.
  - `rx_data` must not change while `rx_valid`=1 and `rx_ready`=0.
- A new start edge is accepted in IDLE the cycle after the stop sample. Back-to-back frames with a 1-bit stop are supported.

## Timing
- Let S be the first rising edge where IDLE sees `rxd_s`=0.
- Start-bit sample at S+HALF_PERIOD.
- Data bit i (0..7) sampled at S+HALF_PERIOD+(i+1)·BIT_PERIOD.
- Stop bit sampled at S+HALF_PERIOD+9·BIT_PERIOD.
- `rx_valid`, `frame_err` and `overrun` are registered and appear one cycle after the stop sample.
- Pin-to-`rx_valid` latency: 2 + HALF_PERIOD + 9·BIT_PERIOD + 1 cycles. With defaults this is 2+217+3906+1 = 4126 cycles after the `rxd` falling edge.
- `busy` rises at S+1 and falls on the cycle IDLE is re-entered.
- Baud tolerance: sampling at ±½ bit from a HALF_PERIOD reference. A ±2% baud mismatch must still decode correctly.

## Test plan
- Nominal frames: drive 0xA5, 0x3C, 0x7F, 0x00, 0xFF at 434 cycles/bit with `rx_ready`=1.
  - Required: five `rx_valid` pulses with matching `rx_data`.
  - Required: each `rx_valid` 4126±1 cycles after its start edge.
  - Required: no `frame_err` and no `overrun`.
- Glitch: hold `rxd` low for 100 cycles, then high.
  - Required: START aborts and `busy` returns low.
  - Required: no `rx_valid`, no `frame_err`.
- Framing error: send 0x55 with the stop bit driven 0 and the line held low for 2000 more cycles.
  - Required: one `frame_err` pulse and no `rx_valid`.
  - Required: the FSM stays in BREAK until the line goes high; a following 0x3C is then received correctly.
- Overrun and backpressure: send 0x7F then 0x00 with `rx_ready`=0.
  - Required: `rx_data` stays 0x7F and `overrun` pulses once at the second stop sample.
  - Then assert `rx_ready` for one cycle. Required: `rx_valid` drops.
  - Repeat with `rx_ready` asserted exactly on the second byte's delivery cycle. Required: `rx_data`=0x00, `rx_valid` stays high, no `overrun`.
- Reset mid-frame: assert `rst_n` during data bit 4 of 0xA5, then release.
  - Required: all outputs at reset values and no byte delivered.
  - Required: a following 0xFF is received cleanly.
- Baud skew: send 0xA5 at 425 and 443 cycles/bit. Required: both decode to 0xA5 with no `frame_err`.
